// File: rtl/cj_pkg.sv
// Shared definitions for the cj_pair_sum acquisition front end:
// FSM state encoding, default widths and the pair-sum width helper.
package cj_pkg;

    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2,
        ST_DONE   = 2'd3
    } cj_state_e;

    // Adding two DW-bit unsigned samples needs exactly one extra bit.
    function automatic int unsigned sum_w(input int unsigned dw);
        return dw + 1;
    endfunction

endpackage

// File: rtl/cj_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module cj_sat_cnt
    import cj_pkg::*;
#(
    parameter int unsigned W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/cj_pair_sum.sv
// Pairs consecutive ADC samples into DW+1-bit sums for the sample FIFO over a
// fixed-length capture. CJ_DROP_CNT_EN adds the saturating drop_cnt port.
module cj_pair_sum
    import cj_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned CAP_LEN = 1024,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                   cj_clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DW-1:0]          adc_data,
    input  logic                   adc_valid,
    input  logic                   fifo_afull,
    output logic [sum_w(DW)-1:0]   sum1,
    output logic                   vs_s,
    output logic                   busy,
    output logic                   done
`ifdef CJ_DROP_CNT_EN
    ,
    output logic [CNT_W-1:0]       drop_cnt
`endif
);

    localparam int unsigned      SW       = sum_w(DW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CAP_LEN - 1);

    cj_state_e         state;
    logic [DW-1:0]     sample_a;
    logic [CNT_W-1:0]  pair_cnt;

    // Capture FSM; the pair counter counts written and dropped pairs alike.
    always_ff @(posedge cj_clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sample_a <= '0;
            pair_cnt <= '0;
            sum1     <= '0;
            vs_s     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            vs_s <= 1'b0;
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    pair_cnt <= '0;
                    if (start) begin
                        state <= ST_FIRST;
                        busy  <= 1'b1;
                    end
                end
                ST_FIRST: begin
                    if (adc_valid) begin
                        sample_a <= adc_data;
                        state    <= ST_SECOND;
                    end
                end
                ST_SECOND: begin
                    if (adc_valid) begin
                        // almost-full only matters on the second sample of a pair
                        if (!fifo_afull) begin
                            sum1 <= SW'(sample_a) + SW'(adc_data);
                            vs_s <= 1'b1;
                        end
                        pair_cnt <= pair_cnt + CNT_W'(1);
                        if (pair_cnt == LAST_CNT) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FIRST;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CJ_DROP_CNT_EN
    logic drop_clr;
    logic drop_inc;

    // Cleared on the IDLE->FIRST transition so each capture reports its own drops.
    assign drop_clr = (state == ST_IDLE) && start;
    assign drop_inc = (state == ST_SECOND) && adc_valid && fifo_afull;

    cj_sat_cnt #(
        .W(CNT_W)
    ) u_drop_cnt (
        .clk (cj_clk),
        .rst (rst),
        .clr (drop_clr),
        .inc (drop_inc),
        .cnt (drop_cnt)
    );
`endif

endmodule

// File: tb/tb_cj_pair_sum.sv
// Scoreboard bench for cj_pair_sum: three instances (CAP_LEN 2, 4 and 15 with a
// 4-bit counter) share the sample bus; one capture is active at a time.
module tb_cj_pair_sum;

    localparam int unsigned NI = 3;

    typedef struct {
        logic [8:0] sum;
        int         cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 adc_valid;
    logic                 fifo_afull;
    logic [7:0]           adc_data;
    logic [NI-1:0]        start_w;
    logic [NI-1:0]        vs_w;
    logic [NI-1:0]        busy_w;
    logic [NI-1:0]        done_w;
    logic [NI-1:0][8:0]   sum_w;
`ifdef CJ_DROP_CNT_EN
    logic [15:0]          drop0;
    logic [15:0]          drop1;
    logic [3:0]           drop2;
`endif

    int   cyc;
    int   n_cmp;
    int   n_err;
    int   active;
    int   done_cnt [NI];
    int   vs_cnt   [NI];
    exp_t exp_q    [NI][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cj_pair_sum #(.CAP_LEN(2)) u_dut2 (
        .cj_clk(clk), .rst(rst), .start(start_w[0]), .adc_data(adc_data),
        .adc_valid(adc_valid), .fifo_afull(fifo_afull), .sum1(sum_w[0]),
        .vs_s(vs_w[0]), .busy(busy_w[0]), .done(done_w[0])
`ifdef CJ_DROP_CNT_EN
        , .drop_cnt(drop0)
`endif
    );

    cj_pair_sum #(.CAP_LEN(4)) u_dut4 (
        .cj_clk(clk), .rst(rst), .start(start_w[1]), .adc_data(adc_data),
        .adc_valid(adc_valid), .fifo_afull(fifo_afull), .sum1(sum_w[1]),
        .vs_s(vs_w[1]), .busy(busy_w[1]), .done(done_w[1])
`ifdef CJ_DROP_CNT_EN
        , .drop_cnt(drop1)
`endif
    );

    cj_pair_sum #(.CAP_LEN(15), .CNT_W(4)) u_dut15 (
        .cj_clk(clk), .rst(rst), .start(start_w[2]), .adc_data(adc_data),
        .adc_valid(adc_valid), .fifo_afull(fifo_afull), .sum1(sum_w[2]),
        .vs_s(vs_w[2]), .busy(busy_w[2]), .done(done_w[2])
`ifdef CJ_DROP_CNT_EN
        , .drop_cnt(drop2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write-side monitor: every vs_s pulse must match the head of its queue.
    always @(negedge clk) begin
        for (int k = 0; k < int'(NI); k++) begin
            if (done_w[k]) done_cnt[k]++;
            if (vs_w[k]) begin
                exp_t e;
                vs_cnt[k]++;
                check("vs_while_busy", 32'(busy_w[k]), 32'd1);
                if (exp_q[k].size() == 0) begin
                    check("vs_unexpected", 32'(vs_w[k]), 32'd0);
                end else begin
                    e = exp_q[k].pop_front();
                    check("sum1", 32'(sum_w[k]), 32'(e.sum));
                    check("vs_latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic af);
        @(posedge clk);
        #1;
        adc_valid  = v;
        adc_data   = d;
        fifo_afull = af;
    endtask

    // One pair: sample A, gap idle cycles (afull high to show it is ignored), sample B.
    task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic af, input int gap);
        exp_t e;
        drive(1'b1, a, 1'b0);
        repeat (gap) drive(1'b0, 8'hAA, 1'b1);
        drive(1'b1, b, af);
        if (!af) begin
            e.sum = 9'(a) + 9'(b);
            e.cyc = cyc + 1;
            exp_q[active].push_back(e);
        end
    endtask

    task automatic pulse_start(input int k);
        @(posedge clk);
        #1;
        adc_valid  = 1'b0;
        start_w[k] = 1'b1;
        @(posedge clk);
        #1;
        start_w[k] = 1'b0;
    endtask

    task automatic start_cap(input int k);
        active = k;
        pulse_start(k);
        @(negedge clk);
        check("busy_after_start", 32'(busy_w[k]), 32'd1);
    endtask

    // Called right after the final pair: done with busy high, then busy low.
    task automatic end_check(input int k);
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(done_w[k]), 32'd1);
        check("busy_in_done", 32'(busy_w[k]), 32'd1);
        @(negedge clk);
        check("busy_fall", 32'(busy_w[k]), 32'd0);
        check("done_single", 32'(done_w[k]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int d0;
        rst        = 1'b1;
        start_w    = '0;
        adc_valid  = 1'b0;
        adc_data   = '0;
        fifo_afull = 1'b0;
        active     = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < int'(NI); k++) begin
            check("rst_sum1", 32'(sum_w[k]), 32'd0);
            check("rst_vs_s", 32'(vs_w[k]), 32'd0);
            check("rst_busy", 32'(busy_w[k]), 32'd0);
            check("rst_done", 32'(done_w[k]), 32'd0);
        end
`ifdef CJ_DROP_CNT_EN
        check("rst_drop", 32'(drop1), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) drive(1'b1, 8'h33, 1'b0);  // discarded in IDLE

        // Basic pair, CAP_LEN=2, back-to-back samples
        v0 = vs_cnt[0];
        d0 = done_cnt[0];
        start_cap(0);
        pair(8'h10, 8'h20, 1'b0, 0);
        pair(8'hFF, 8'hFF, 1'b0, 0);
        end_check(0);
        check("basic_vs_count", 32'(vs_cnt[0] - v0), 32'd2);
        check("basic_done_count", 32'(done_cnt[0] - d0), 32'd1);

        // Back-pressure on the second pair, CAP_LEN=4
        v0 = vs_cnt[1];
        start_cap(1);
        pair(8'h01, 8'h02, 1'b0, 0);
        pair(8'h03, 8'h04, 1'b1, 0);
        pair(8'h05, 8'h06, 1'b0, 0);
        pair(8'h80, 8'h7F, 1'b0, 0);
        end_check(1);
        check("bp_vs_count", 32'(vs_cnt[1] - v0), 32'd3);
        check("bp_sum1_hold", 32'(sum_w[1]), 32'h0FF);
`ifdef CJ_DROP_CNT_EN
        check("bp_drop_cnt", 32'(drop1), 32'd1);
`endif

        // Gapped valid: one valid every 3 cycles
        start_cap(0);
        pair(8'd1, 8'd2, 1'b0, 2);
        repeat (2) drive(1'b0, 8'h00, 1'b1);
        pair(8'd3, 8'd4, 1'b0, 2);
        end_check(0);

        // Start re-pulsed mid-capture must not restart it
        v0 = vs_cnt[1];
        d0 = done_cnt[1];
        start_cap(1);
        pair(8'h11, 8'h22, 1'b0, 0);
        pulse_start(1);
        pair(8'h33, 8'h44, 1'b0, 0);
        pair(8'h55, 8'h66, 1'b0, 1);
        pulse_start(1);
        pair(8'h77, 8'h88, 1'b0, 0);
        end_check(1);
        check("restart_vs_count", 32'(vs_cnt[1] - v0), 32'd4);
        check("restart_done_count", 32'(done_cnt[1] - d0), 32'd1);
`ifdef CJ_DROP_CNT_EN
        check("restart_drop_clr", 32'(drop1), 32'd0);
`endif
        drive(1'b1, 8'h09, 1'b0);
        drive(1'b1, 8'h09, 1'b0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("idle_discard", 32'(vs_cnt[1] - v0), 32'd4);

        // Reset after sample A aborts the capture
        d0 = done_cnt[0];
        start_cap(0);
        drive(1'b1, 8'h55, 1'b0);
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_sum1", 32'(sum_w[0]), 32'd0);
        check("abort_vs_s", 32'(vs_w[0]), 32'd0);
        check("abort_busy", 32'(busy_w[0]), 32'd0);
        check("abort_done", 32'(done_w[0]), 32'd0);
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("abort_no_done", 32'(done_cnt[0] - d0), 32'd0);
        start_cap(0);
        pair(8'h40, 8'h02, 1'b0, 0);
        pair(8'h03, 8'h04, 1'b0, 0);
        end_check(0);

        // Every pair dropped on the 4-bit instance; extra pairs land after DONE
        v0 = vs_cnt[2];
        d0 = done_cnt[2];
        start_cap(2);
        for (int i = 0; i < 20; i++) begin
            pair(8'(i), 8'(i + 1), 1'b1, 0);
        end
        repeat (3) drive(1'b0, 8'h00, 1'b0);
        check("sat_no_vs", 32'(vs_cnt[2] - v0), 32'd0);
        check("sat_done_count", 32'(done_cnt[2] - d0), 32'd1);
        check("sat_busy_low", 32'(busy_w[2]), 32'd0);
`ifdef CJ_DROP_CNT_EN
        check("sat_drop_cnt", 32'(drop2), 32'hF);
`endif

        repeat (3) @(posedge clk);
        for (int k = 0; k < int'(NI); k++) begin
            check("queue_drained", 32'(exp_q[k].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
